// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - EXU/LSU completion bus into the register-file write port
// Purpose: bundles both completion requests, their readys, the flush input and the
//          registered register-file write outputs with the retire counter.
// Modports: master - completion sources and register file (drive requests, see results)
//           slave  - wb_port_arbiter (grants requests, drives the write port)
// Parameters: XLEN - write data width, CNT_W - retire counter width.
interface wb_port_arbiter_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             i_exu_valid;
    logic [4:0]       i_exu_rd;
    logic [XLEN-1:0]  i_exu_wdata;
    logic             o_exu_ready;
    logic             i_lsu_valid;
    logic [4:0]       i_lsu_rd;
    logic [XLEN-1:0]  i_lsu_wdata;
    logic             o_lsu_ready;
    logic             i_flush;
    logic             o_reg_wen;
    logic [4:0]       o_rd_addr;
    logic [XLEN-1:0]  o_rd_wdata;
    logic [CNT_W-1:0] o_retire_cnt;

    modport master (
        output i_exu_valid, i_exu_rd, i_exu_wdata,
        output i_lsu_valid, i_lsu_rd, i_lsu_wdata,
        output i_flush,
        input  o_exu_ready, o_lsu_ready,
        input  o_reg_wen, o_rd_addr, o_rd_wdata, o_retire_cnt
    );

    modport slave (
        input  i_exu_valid, i_exu_rd, i_exu_wdata,
        input  i_lsu_valid, i_lsu_rd, i_lsu_wdata,
        input  i_flush,
        output o_exu_ready, o_lsu_ready,
        output o_reg_wen, o_rd_addr, o_rd_wdata, o_retire_cnt
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - arbitrates EXU and LSU completions onto one register-file write port
// Purpose: grants at most one completion per cycle, registers the chosen write for one
//          cycle and counts committed (non-flushed) writes, including x0 writes.
// Ports:   i_clk - clock; i_rst - synchronous active-high reset;
//          bus   - wb_port_arbiter_if.slave (requests, readys, flush, write port, counter).
// Parameters: XLEN, STARVE_LIMIT (base build only), CNT_W.
// Build option: YSYX_24090003_WB_RR_EN selects round-robin arbitration; when undefined,
//               LSU has fixed priority with an EXU starvation guard.
module wb_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    wb_port_arbiter_if.slave   bus
);
    logic             exu_grant;
    logic             lsu_grant;
    logic             xfer;
    logic             commit;
    logic [4:0]       sel_rd;
    logic [XLEN-1:0]  sel_wdata;

    logic             reg_wen;
    logic [4:0]       rd_addr;
    logic [XLEN-1:0]  rd_wdata;
    logic [CNT_W-1:0] retire_cnt;

`ifdef YSYX_24090003_WB_RR_EN
    // 1 = EXU preferred on the next conflict, 0 = LSU preferred.
    logic ptr_exu;
`else
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
    logic [SW-1:0] starve_cnt;
`endif

    always_comb begin
        exu_grant = 1'b0;
        lsu_grant = 1'b0;
`ifdef YSYX_24090003_WB_RR_EN
        if (bus.i_exu_valid && bus.i_lsu_valid) begin
            exu_grant = ptr_exu;
            lsu_grant = !ptr_exu;
        end else begin
            exu_grant = bus.i_exu_valid;
            lsu_grant = bus.i_lsu_valid;
        end
`else
        // A starved EXU overrides the LSU's fixed priority.
        exu_grant = bus.i_exu_valid && (!bus.i_lsu_valid || starve_cnt == LIMIT);
        lsu_grant = bus.i_lsu_valid && !exu_grant;
`endif
    end

    assign xfer      = exu_grant || lsu_grant;
    assign commit    = xfer && !bus.i_flush;
    assign sel_rd    = exu_grant ? bus.i_exu_rd    : bus.i_lsu_rd;
    assign sel_wdata = exu_grant ? bus.i_exu_wdata : bus.i_lsu_wdata;

    assign bus.o_exu_ready  = exu_grant;
    assign bus.o_lsu_ready  = lsu_grant;
    assign bus.o_reg_wen    = reg_wen;
    assign bus.o_rd_addr    = rd_addr;
    assign bus.o_rd_wdata   = rd_wdata;
    assign bus.o_retire_cnt = retire_cnt;

    // Write port: x0 writes retire but never enable the register file, and the
    // address/data stay put whenever no real write is issued.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            reg_wen    <= 1'b0;
            rd_addr    <= '0;
            rd_wdata   <= '0;
            retire_cnt <= '0;
        end else begin
            reg_wen <= commit && (sel_rd != 5'd0);
            if (commit && (sel_rd != 5'd0)) begin
                rd_addr  <= sel_rd;
                rd_wdata <= sel_wdata;
            end
            if (commit) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
        end
    end

    // Arbitration state ignores flush: a flushed transfer still counts as a grant.
`ifdef YSYX_24090003_WB_RR_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_exu <= 1'b0;
        end else if (exu_grant) begin
            ptr_exu <= 1'b0;
        end else if (lsu_grant) begin
            ptr_exu <= 1'b1;
        end
    end
`else
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            starve_cnt <= '0;
        end else if (bus.i_exu_valid && !exu_grant) begin
            if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + SW'(1);
            end
        end else begin
            starve_cnt <= '0;
        end
    end
`endif
endmodule
